card_dealer: RTL
================

# card_dealer

Card source for the BlackJack game FSM. Consumes the free-running count from the timing counter as a random seed and returns one card per request from a tracked 52-card deck (4 of each rank). After every dealt card it holds for a fixed two-second display window before accepting the next request. It sits between the counter and the game FSM, which only sees a draw/valid handshake.

## Interface

- CLK_HZ, 50_000_000, clock frequency in Hz.
- HOLD_MS, 2000, post-deal hold window in ms; HOLD_CYCLES = CLK_HZ/1000*HOLD_MS, and benches override it small.
- SEED_WIDTH, 12, width of i_Seed.

- clk_50M  in  1  system clock.
- i_Reset  in  1  reset; synchronous, active-high; clock clk_50M.
- i_Seed  in  SEED_WIDTH  free-running count, unsigned.
- i_Draw  in  1  draw request, level, sampled only in IDLE.
- i_Shuffle  in  1  refill deck, sampled only in IDLE.
- o_Valid  out  1  one-cycle pulse: o_Card/o_Points hold a new card.
- o_Card  out  4  rank 1..13 (1 = Ace, 11/12/13 = J/Q/K); holds last dealt value.
- o_Points  out  4  Ace = 1, 2..10 = face value, J/Q/K = 10.
- o_Busy  out  1  high in PROBE and HOLD.
- o_Hold  out  1  high in HOLD only.
- o_Empty  out  1  high when o_Remaining == 0.
- o_Remaining  out  6  cards left, 0..52.

## Operation

- Deck state: 13 rank counters, 3 bits each, range 0..4, plus a 6-bit total.
- States: IDLE, PROBE, HOLD.
- IDLE, priority order:
  - i_Shuffle=1: set all rank counters to 4 and the total to 52. Stay in IDLE. A simultaneous i_Draw is dropped.
  - Otherwise i_Draw=1 and total>0: latch index r = i_Seed mod 13 (0..12), go to PROBE.
  - Otherwise i_Draw=1 and total==0: ignored. Stay in IDLE, no o_Valid.
- PROBE, once per cycle:
  - If count[r] > 0: decrement count[r] and the total, register o_Card = r+1 and o_Points, pulse o_Valid, load hold counter, go to HOLD.
  - Else: r = (r==12) ? 0 : r+1, stay in PROBE.
  - Because total>0 on entry, at most 12 misses occur.
- HOLD: count down HOLD_CYCLES cycles, then go to IDLE. i_Draw and i_Shuffle are ignored.
- The hold counter is ceil(log2(HOLD_CYCLES+1)) bits, 27 at the defaults.
- The mod-13 reduction is combinational on the full SEED_WIDTH value. The implementation method is free, but the result must equal the arithmetic modulo.
- Reset values:
  - state IDLE.
  - rank counters all 4, o_Remaining 52.
  - o_Card 0, o_Points 0.
  - o_Valid, o_Busy, o_Hold, o_Empty all 0.
- Reset mid-PROBE or mid-HOLD: immediate return to reset values with a full deck. A pending draw is lost and no o_Valid is produced.

## Timing

- i_Draw high at edge N (IDLE) → PROBE from N+1. With k misses, o_Valid is high for exactly the cycle following edge N+1+k.
- o_Card, o_Points and o_Remaining update on the same edge that raises o_Valid.
- o_Busy rises after edge N and stays high through the last HOLD cycle.
- o_Hold is high for exactly HOLD_CYCLES cycles, starting the cycle o_Valid is high.
- The first IDLE cycle after HOLD can accept a new draw. A level-held i_Draw therefore deals once per 2+k+HOLD_CYCLES cycles.
- o_Empty is combinational from the total register. It rises the cycle the 52nd card's o_Valid is high.
- Shuffle takes effect on the next edge: o_Remaining = 52 one cycle after i_Shuffle is sampled.

## Test plan

- Reset, then idle 5 cycles → o_Remaining=52, o_Card=0, o_Points=0, and o_Valid/o_Busy/o_Hold/o_Empty all 0.
- HOLD_CYCLES=4, i_Seed=0, one i_Draw pulse → o_Valid 2 cycles later with o_Card=1, o_Points=1, o_Remaining=51, then o_Hold for 4 cycles. Repeat with i_Seed=25 → o_Card=13, o_Points=10.
- i_Seed fixed at 13, five draws → first four give o_Card=1. The fifth probes once, gives o_Card=2 with o_Valid 3 cycles after its draw, and leaves o_Remaining=47.
- 52 draws with random seeds → each rank is dealt exactly 4 times and o_Empty=1 after the last. A 53rd draw produces no o_Valid. i_Shuffle then restores o_Remaining=52 and clears o_Empty.
- i_Draw and i_Shuffle pulsed during HOLD → both ignored, o_Remaining unchanged. i_Draw and i_Shuffle together in IDLE → shuffle only, no o_Valid.
- i_Reset asserted in PROBE, and separately in the 2nd HOLD cycle → the next cycle shows reset values, o_Remaining=52 and no o_Valid.

Source files
------------

// File: rtl/card_dealer.sv
// Card source for the BlackJack FSM: deals one card per draw from a tracked
// 52-card deck, using the free-running seed to pick the starting rank.
module card_dealer #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int HOLD_MS     = 2000,
    parameter int SEED_WIDTH  = 12,
    parameter int HOLD_CYCLES = CLK_HZ / 1000 * HOLD_MS
) (
    input  logic                  clk_50M,
    input  logic                  i_Reset,
    input  logic [SEED_WIDTH-1:0] i_Seed,
    input  logic                  i_Draw,
    input  logic                  i_Shuffle,
    output logic                  o_Valid,
    output logic [3:0]            o_Card,
    output logic [3:0]            o_Points,
    output logic                  o_Busy,
    output logic                  o_Hold,
    output logic                  o_Empty,
    output logic [5:0]            o_Remaining
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      rank_cnt [0:12];
    logic [5:0]      total;
    logic [3:0]      probe_idx;
    logic [HC_W-1:0] hold_cnt;
    logic            hit;
    logic [3:0]      seed_mod;

    // Shift-and-subtract reduction: the running remainder never exceeds 12,
    // so doubling plus one bit fits in 5 bits.
    function automatic logic [3:0] mod13(input logic [SEED_WIDTH-1:0] v);
        logic [4:0] acc;
        acc = 5'd0;
        for (int i = SEED_WIDTH - 1; i >= 0; i--) begin
            acc = {acc[3:0], v[i]};
            if (acc >= 5'd13)
                acc = acc - 5'd13;
        end
        return acc[3:0];
    endfunction

    function automatic logic [3:0] rank_points(input logic [3:0] idx);
        return (idx >= 4'd10) ? 4'd10 : idx + 4'd1;
    endfunction

    assign seed_mod    = mod13(i_Seed);
    assign hit         = (rank_cnt[probe_idx] != 3'd0);
    assign o_Remaining = total;
    assign o_Empty     = (total == 6'd0);
    assign o_Busy      = (state != IDLE);
    assign o_Hold      = (state == HOLD);

    always_ff @(posedge clk_50M) begin
        if (i_Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!i_Shuffle && i_Draw && total != 6'd0)
                    state_nxt = PROBE;
            end
            PROBE: begin
                if (hit)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (hold_cnt == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            for (int i = 0; i < 13; i++)
                rank_cnt[i] <= 3'd4;
            total     <= 6'd52;
            probe_idx <= 4'd0;
            hold_cnt  <= '0;
            o_Valid   <= 1'b0;
            o_Card    <= 4'd0;
            o_Points  <= 4'd0;
        end else begin
            o_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Shuffle) begin
                        for (int i = 0; i < 13; i++)
                            rank_cnt[i] <= 3'd4;
                        total <= 6'd52;
                    end else if (i_Draw && total != 6'd0) begin
                        probe_idx <= seed_mod;
                    end
                end
                PROBE: begin
                    if (hit) begin
                        rank_cnt[probe_idx] <= rank_cnt[probe_idx] - 3'd1;
                        total    <= total - 6'd1;
                        o_Card   <= probe_idx + 4'd1;
                        o_Points <= rank_points(probe_idx);
                        o_Valid  <= 1'b1;
                        hold_cnt <= HC_W'(HOLD_CYCLES - 1);
                    end else begin
                        // Walk upward to the next rank that still has cards.
                        probe_idx <= (probe_idx == 4'd12) ? 4'd0 : probe_idx + 4'd1;
                    end
                end
                HOLD: begin
                    if (hold_cnt != '0)
                        hold_cnt <= hold_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
